// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock programmable FIFO: pointer sizing,
// read-mode encoding and the elaboration-time parameter legality check.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int size);
    return $clog2(size) + 1;
  endfunction

  localparam int DEF_SIZE  = 16;
  localparam int DEF_PTR_W = ptr_width(DEF_SIZE);

  function automatic bit params_ok(input int bits, input int size,
                                   input int afull_th, input int aempty_th);
    return (bits >= 1) && (size >= 4) && ((size & (size - 1)) == 0) &&
           (afull_th >= 1) && (afull_th <= size) &&
           (aempty_th >= 0) && (aempty_th <= size - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(SIZE)-1:0]  wr_addr,
  input  logic [BITS-1:0]          wr_data,
  input  logic [$clog2(SIZE)-1:0]  rd_addr,
  output logic [BITS-1:0]          rd_data
);

  logic [BITS-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags, fill level, sticky error
// flags and an optional first-word-fall-through head register.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIZE      = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = SIZE - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [BITS-1:0]         wr_data,
  output logic                    wr_full,
  output logic                    wr_almost_full,
  input  logic                    rd_en,
  output logic [BITS-1:0]         rd_data,
  output logic                    rd_valid,
  output logic                    rd_empty,
  output logic                    rd_almost_empty,
  output logic [$clog2(SIZE):0]   level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int            PW       = ptr_width(SIZE);
  localparam int            AW       = PW - 1;
  localparam logic [PW-1:0] SIZE_L   = PW'(SIZE);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_TH);
  localparam fifo_mode_e    MODE     = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  if (!params_ok(BITS, SIZE, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $error("sync_fifo_prog: illegal BITS/SIZE/AFULL_TH/AEMPTY_TH combination");
  end

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [BITS-1:0] mem_rd_data;
  logic            wr_acc;
  logic            rd_acc;

  // Handshake: a write transfers when wr_en && !wr_full, a read when
  // rd_en && !rd_empty; both flags are registered state from before the edge,
  // and a rejected request changes nothing except the sticky error flag.
  assign wr_acc          = wr_en && !wr_full;
  assign rd_acc          = rd_en && !rd_empty;
  assign wr_full         = (level == SIZE_L);
  assign wr_almost_full  = (level >= AFULL_L);
  assign rd_almost_empty = (level <= AEMPTY_L);

  fifo_mem #(.BITS(BITS), .SIZE(SIZE)) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + PW'(1);
        2'b01:   level <= level - PW'(1);
        default: level <= level;
      endcase
      overflow  <= (overflow  && !clr_err) || (wr_en && wr_full);
      underflow <= (underflow && !clr_err) || (rd_en && rd_empty);
    end
  end

  if (MODE == MODE_STD) begin : g_std
    assign rd_empty = (wr_ptr == rd_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr   <= '0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) begin
          rd_data <= mem_rd_data;
          rd_ptr  <= rd_ptr + PW'(1);
        end
      end
    end
  end else begin : g_fwft
    logic mem_empty;
    logic load;

    // rd_data/rd_valid form the head register; refill it from memory whenever
    // it is empty or being popped this cycle, so reads can run back to back.
    assign mem_empty = (wr_ptr == rd_ptr);
    assign load      = !mem_empty && (!rd_valid || rd_acc);
    assign rd_empty  = !rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr   <= '0;
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (load) begin
        rd_data  <= mem_rd_data;
        rd_valid <= 1'b1;
        rd_ptr   <= rd_ptr + PW'(1);
      end else if (rd_acc) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one standard and one FWFT instance share
// stimulus; each pass checks the instance selected by 'mode'.
module tb_sync_fifo_prog;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic       rd_en   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       full_o   [2];
  logic       afull_o  [2];
  logic       valid_o  [2];
  logic       empty_o  [2];
  logic       aempty_o [2];
  logic       ovf_o    [2];
  logic       unf_o    [2];
  logic [7:0] data_o   [2];
  logic [3:0] level_o  [2];

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         wr;
    logic [7:0] data;
    bit         rd;
    bit         clr;
    int         lvl;
    bit         full;
    bit         afull;
    bit         empty_std;
    bit         empty_fwft;
    bit         aempty;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  sync_fifo_prog #(.BITS(8), .SIZE(8), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(full_o[0]), .wr_almost_full(afull_o[0]), .rd_en(rd_en),
    .rd_data(data_o[0]), .rd_valid(valid_o[0]), .rd_empty(empty_o[0]),
    .rd_almost_empty(aempty_o[0]), .level(level_o[0]), .overflow(ovf_o[0]),
    .underflow(unf_o[0]), .clr_err(clr_err)
  );

  sync_fifo_prog #(.BITS(8), .SIZE(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(full_o[1]), .wr_almost_full(afull_o[1]), .rd_en(rd_en),
    .rd_data(data_o[1]), .rd_valid(valid_o[1]), .rd_empty(empty_o[1]),
    .rd_almost_empty(aempty_o[1]), .level(level_o[1]), .overflow(ovf_o[1]),
    .underflow(unf_o[1]), .clr_err(clr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s mode=%0d actual=%0h expected=%0h", name, mode, act, exp);
    end
  endtask

  task automatic chk_flags(input int lvl, input bit full, input bit afull, input bit empty,
                           input bit aempty, input bit ovf, input bit unf);
    chk("level",           level_o[mode],  lvl);
    chk("wr_full",         full_o[mode],   full);
    chk("wr_almost_full",  afull_o[mode],  afull);
    chk("rd_empty",        empty_o[mode],  empty);
    chk("rd_almost_empty", aempty_o[mode], aempty);
    chk("overflow",        ovf_o[mode],    ovf);
    chk("underflow",       unf_o[mode],    unf);
  endtask

  task automatic chk_reset();
    chk_flags(0, 0, 0, 1, 1, 0, 0);
    chk("reset_rd_valid", valid_o[mode], 0);
    chk("reset_rd_data",  data_o[mode],  0);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
  endtask

  task automatic read_one(input logic [7:0] exp, input int lvl_after);
    if (mode == 1) begin
      chk("fwft_head_data",  data_o[1],  exp);
      chk("fwft_head_valid", valid_o[1], 1);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (mode == 0) begin
      chk("std_rd_data",  data_o[0],  exp);
      chk("std_rd_valid", valid_o[0], 1);
    end
    chk("read_level", level_o[mode], lvl_after);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    chk_reset();
    rst_n = 1'b1;
    step();
  endtask

  // Reset asserted between edges while a burst is in flight.
  task automatic reset_test();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_read_underflow", unf_o[mode], 1);
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + k);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk("pre_reset_level",    level_o[mode], 5);
    chk("pre_reset_rd_valid", valid_o[mode], 1);
    chk("pre_reset_rd_data",  data_o[mode],  (mode == 1) ? 8'h32 : 8'h31);
    rd_en = 1'b0; wr_en = 1'b1; wr_data = 8'h37;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    idle();
    step();
    rst_n = 1'b1;
    step();
    chk_reset();
  endtask

  initial begin
    //            wr  data   rd clr  lvl full af es ef ae ovf unf
    vecs[0]  = '{1, 8'h01, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    vecs[1]  = '{1, 8'h02, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 8'h03, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 8'h04, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 8'h05, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 8'h06, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 8'h07, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 8'h08, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 8'hAA, 0, 0, 8, 1, 1, 0, 0, 0, 1, 0};
    vecs[9]  = '{0, 8'h00, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 8'hAB, 0, 1, 8, 1, 1, 0, 0, 0, 1, 0};
    vecs[11] = '{0, 8'h00, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0};

    for (int m = 0; m < 2; m++) begin
      mode = m;
      do_reset();
      reset_test();

      // Fill, overflow and clr_err via the vector table.
      for (int i = 0; i < 12; i++) begin
        wr_en = vecs[i].wr; wr_data = vecs[i].data;
        rd_en = vecs[i].rd; clr_err = vecs[i].clr;
        step();
        chk_flags(vecs[i].lvl, vecs[i].full, vecs[i].afull,
                  (mode == 1) ? vecs[i].empty_fwft : vecs[i].empty_std,
                  vecs[i].aempty, vecs[i].ovf, vecs[i].unf);
        chk("table_rd_valid", valid_o[mode], (mode == 1) ? !vecs[i].empty_fwft : 1'b0);
        if (mode == 1 && !vecs[i].empty_fwft) chk("table_fwft_head", data_o[1], 8'h01);
      end
      idle();

      // Write+read together at full: read wins, write rejected.
      if (mode == 1) chk("full_both_head", data_o[1], 8'h01);
      wr_en = 1'b1; wr_data = 8'hBB; rd_en = 1'b1;
      step();
      idle();
      chk("full_both_level", level_o[mode], 7);
      chk("full_both_ovf",   ovf_o[mode],   1);
      chk("full_both_full",  full_o[mode],  0);
      if (mode == 0) chk("full_both_data", data_o[0], 8'h01);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_ovf", ovf_o[mode], 0);
      chk("std_valid_one_cycle", valid_o[mode], (mode == 1));

      for (int v = 2; v <= 8; v++) read_one(8'(v), 8 - v);
      chk_flags(0, 0, 0, 1, 1, 0, 0);
      step();
      chk("drained_valid", valid_o[mode], 0);
      if (mode == 0) chk("std_data_hold", data_o[0], 8'h08);

      // Write+read together at empty: write wins, read rejected.
      wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
      step();
      idle();
      chk("empty_both_level", level_o[mode], 1);
      chk("empty_both_unf",   unf_o[mode],   1);
      chk("empty_both_empty", empty_o[mode], (mode == 1));
      step();
      chk("empty_both_empty2", empty_o[mode], 0);
      read_one(8'h77, 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_unf", unf_o[mode], 0);

      // Continuous write+read at level 3 across pointer wrap.
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        wr_en = 1'b1; wr_data = 8'(8'h10 + k);
        exp_q.push_back(wr_data);
        step();
      end
      idle();
      chk("wrap_start_level", level_o[mode], 3);
      for (int i = 0; i < 20; i++) begin
        logic [7:0] got;
        if (mode == 1) chk("wrap_head", data_o[1], exp_q[0]);
        wr_en = 1'b1; wr_data = 8'(8'h13 + i); rd_en = 1'b1;
        exp_q.push_back(wr_data);
        step();
        got = exp_q.pop_front();
        if (mode == 0) chk("wrap_data", data_o[0], got);
        chk("wrap_level", level_o[mode], 3);
      end
      idle();
      for (int k = 2; k >= 0; k--) read_one(exp_q.pop_front(), k);
      chk("wrap_empty", empty_o[mode], 1);

      // Single-word latency.
      wr_en = 1'b1; wr_data = 8'h5A;
      step();
      idle();
      chk("lat_empty_1edge", empty_o[mode], (mode == 1));
      step();
      chk("lat_empty_2edge", empty_o[mode], 0);
      if (mode == 1) chk("lat_fwft_data", data_o[1], 8'h5A);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("lat_valid_pulse", valid_o[mode], (mode == 0));
      if (mode == 0) chk("lat_std_data", data_o[0], 8'h5A);
      step();
      chk("lat_valid_clear", valid_o[mode], 0);
      chk("lat_final_empty", empty_o[mode], 1);
      if (mode == 0) chk("lat_data_hold", data_o[0], 8'h5A);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
